// File: rtl/mii_tx_framer_if.sv
// rtl/mii_tx_framer_if.sv - application-side nibble stream into the MII TX framer
interface mii_tx_framer_if;
  logic       tx_vld;
  logic       tx_eof;
  logic [3:0] tx_dat;
  logic       tx_ack;

  modport master (output tx_vld, output tx_eof, output tx_dat, input  tx_ack);
  modport slave  (input  tx_vld, input  tx_eof, input  tx_dat, output tx_ack);
endinterface

// File: rtl/mii_tx_framer.sv
// rtl/mii_tx_framer.sv - MII nibble TX framer: preamble/SFD, padding, CRC-32 FCS, IFG, underrun
module mii_tx_framer #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_DATA_NIBBLES = 120,
  parameter int IFG_NIBBLES      = 24,
  parameter bit APPEND_FCS       = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  mii_tx_framer_if.slave   tx_if,
  output logic             mii_tx_en_o,
  output logic [3:0]       mii_tx_dat_o,
  output logic             busy_o,
  output logic             underrun_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] underrun_cnt_o
);

  localparam int CMAX = (PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES : IFG_NIBBLES;
  localparam int CW   = $clog2(((CMAX > 8) ? CMAX : 8) + 1);
  localparam int LW   = $clog2(MIN_DATA_NIBBLES + 2);
  localparam logic [CW-1:0] PRE_LOAD = CW'(PREAMBLE_NIBBLES);
  localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_NIBBLES - 1);
  localparam logic [LW-1:0] MIN_LEN  = LW'(MIN_DATA_NIBBLES);
  localparam logic [31:0]   CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic             odd_q, odd_d;
  logic [31:0]      crc_q, crc_d;
  logic             corrupt_q, corrupt_d;
  logic             discard_q, discard_d;
  logic             en_q, en_d;
  logic [3:0]       dat_q, dat_d;
  logic             ur_q, ur_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] ur_cnt_q, ur_cnt_d;
  logic             ack;
  logic             tail;
  logic             go_ifg;
  logic [31:0]      fcs_word;

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    odd_d       = odd_q;
    crc_d       = crc_q;
    corrupt_d   = corrupt_q;
    discard_d   = discard_q;
    en_d        = 1'b0;
    dat_d       = 4'h0;
    ur_d        = 1'b0;
    frame_cnt_d = frame_cnt_q;
    ur_cnt_d    = ur_cnt_q;
    ack         = 1'b0;
    tail        = 1'b0;
    go_ifg      = 1'b0;
    fcs_word    = ~crc_q ^ {32{corrupt_q}};

    // Flush the leftovers of an abandoned frame while the line is quiet.
    if ((state_q == S_IDLE || state_q == S_IFG) && discard_q) begin
      ack = 1'b1;
      if (tx_if.tx_vld && tx_if.tx_eof) discard_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_if.tx_vld && !discard_q) begin
          state_d = S_PRE;
          cnt_d   = PRE_LOAD;
        end
      end
      S_PRE: begin
        en_d  = 1'b1;
        dat_d = 4'h5;
        if (cnt_q == CW'(1)) state_d = S_SFD;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      S_SFD: begin
        en_d      = 1'b1;
        dat_d     = 4'hD;
        crc_d     = '1;
        len_d     = '0;
        odd_d     = 1'b0;
        corrupt_d = 1'b0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        ack  = 1'b1;
        en_d = 1'b1;
        if (tx_if.tx_vld) begin
          dat_d = tx_if.tx_dat;
          crc_d = crc_nibble(crc_q, tx_if.tx_dat);
          len_d = (len_q < MIN_LEN) ? len_q + 1'b1 : len_q;
          odd_d = ~odd_q;
          if (tx_if.tx_eof) begin
            if (len_d < MIN_LEN || odd_d) state_d = S_PAD;
            else                          tail    = 1'b1;
          end
        end else begin
          crc_d     = crc_nibble(crc_q, 4'h0);
          ur_d      = 1'b1;
          ur_cnt_d  = ur_cnt_q + 1'b1;
          corrupt_d = 1'b1;
          discard_d = 1'b1;
          tail      = 1'b1;
        end
      end
      S_PAD: begin
        en_d  = 1'b1;
        crc_d = crc_nibble(crc_q, 4'h0);
        len_d = (len_q < MIN_LEN) ? len_q + 1'b1 : len_q;
        odd_d = ~odd_q;
        if (!(len_d < MIN_LEN) && !odd_d) tail = 1'b1;
      end
      S_FCS: begin
        en_d  = 1'b1;
        dat_d = fcs_word[{cnt_q[2:0], 2'b00} +: 4];
        if (cnt_q[2:0] == 3'd7) go_ifg = 1'b1;
        else                    cnt_d  = cnt_q + 1'b1;
      end
      S_IFG: begin
        if (cnt_q == CW'(1)) state_d = S_IDLE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (tail) begin
      if (APPEND_FCS) begin
        state_d = S_FCS;
        cnt_d   = '0;
      end else begin
        go_ifg = 1'b1;
      end
    end

    // The idle cycle in S_IDLE is part of the gap, so S_IFG itself lasts one cycle less.
    if (go_ifg) begin
      if (!corrupt_d) frame_cnt_d = frame_cnt_q + 1'b1;
      corrupt_d = 1'b0;
      cnt_d     = IFG_LOAD;
      state_d   = (IFG_NIBBLES > 1) ? S_IFG : S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      odd_q       <= 1'b0;
      crc_q       <= '1;
      corrupt_q   <= 1'b0;
      discard_q   <= 1'b0;
      en_q        <= 1'b0;
      dat_q       <= 4'h0;
      ur_q        <= 1'b0;
      frame_cnt_q <= '0;
      ur_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      odd_q       <= odd_d;
      crc_q       <= crc_d;
      corrupt_q   <= corrupt_d;
      discard_q   <= discard_d;
      en_q        <= en_d;
      dat_q       <= dat_d;
      ur_q        <= ur_d;
      frame_cnt_q <= frame_cnt_d;
      ur_cnt_q    <= ur_cnt_d;
    end
  end

  assign tx_if.tx_ack   = ack;
  assign mii_tx_en_o    = en_q;
  assign mii_tx_dat_o   = dat_q;
  assign busy_o         = (state_q != S_IDLE);
  assign underrun_o     = ur_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign underrun_cnt_o = ur_cnt_q;

endmodule

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
- Parametrised successor to the current nibble TX MAC.
- Takes a nibble stream (vld/eof/dat with ack) from the application side, e.g. kvs, and drives MII TX pins (tx_en, txd[3:0]).
- Inserts preamble/SFD, pads short frames, appends CRC-32 FCS and enforces the inter-frame gap.
- Adds features the fixed MAC lacks: configurable preamble/pad/IFG, optional FCS, underrun detection with frame corruption, and a sent-frame counter.

Parameters:
- PREAMBLE_NIBBLES, 15, count of 0x5 nibbles before the 0xD SFD nibble (1..63).
- MIN_DATA_NIBBLES, 120, minimum payload nibbles before FCS; shorter frames are zero-padded (0 disables padding).
- IFG_NIBBLES, 24, idle cycles enforced after the last FCS/data nibble (≥1).
- APPEND_FCS, 1, 1 = compute and append CRC-32 FCS; 0 = end frame after payload/pad.
- CNT_W, 16, width of frame and underrun counters.

Ports:
- clk  in  1  MII TX clock (25 MHz), all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- tx_vld  in  1  payload nibble valid.
- tx_eof  in  1  marks the last payload nibble of the frame (qualified by tx_vld).
- tx_dat  in  4  payload nibble, MII order (low nibble of each byte first).
- tx_ack  out  1  nibble accepted this cycle when tx_vld&&tx_ack.
- mii_tx_en  out  1  registered MII TX enable.
- mii_tx_dat  out  4  registered MII TX data.
- busy  out  1  high in any state except IDLE.
- underrun  out  1  one-cycle pulse when underrun is detected.
- frame_cnt  out  CNT_W  frames completed, wraps modulo 2^CNT_W.
- underrun_cnt  out  CNT_W  underruns detected, wraps.

Behaviour:
- Reset (rstn low, async): state=IDLE; tx_ack=0, mii_tx_en=0, mii_tx_dat=0, busy=0, underrun=0, both counters=0. Reset mid-frame truncates immediately; tx_en drops asynchronously.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: when tx_vld=1 → PRE, without consuming the nibble. The preamble counter is loaded.
- PRE: drives 0x5 for PREAMBLE_NIBBLES cycles, then → SFD.
- SFD: drives 0xD for one cycle, then → DATA. CRC register = 0xFFFFFFFF and the nibble counter = 0 at SFD.
- DATA:
  - tx_ack is combinational = (state==DATA). Each accepted nibble is output, folded into the CRC and counts toward length.
  - Accepted nibble with tx_eof → PAD if padding is needed, else → FCS (APPEND_FCS=1) or → IFG.
  - Padding is needed if count < MIN_DATA_NIBBLES or count is odd; odd frames are padded to a byte boundary.
- Underrun: tx_vld=0 in DATA:
  - Pulse underrun; underrun_cnt++.
  - Drive nibble 0x0 and fold it into the CRC.
  - Go to FCS with a corrupt flag set; the FCS is emitted bit-inverted so the receiver discards the frame.
  - If APPEND_FCS=0, go to IFG instead.
  - Nibbles of the abandoned frame remaining upstream are discarded: tx_ack=1 in IFG/IDLE while a discard flag is set, until an accepted tx_eof.
- PAD: drives 0x0 (folded into the CRC) until count ≥ MIN_DATA_NIBBLES and count is even, then → FCS or IFG.
- FCS:
  - Emits ~crc as 8 nibbles, LSB nibble first: nibble k = (~crc >> 4k) & 0xF.
  - Inverted again if the corrupt flag is set.
  - Then → IFG.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, updated 4 bits/cycle, LSB of the nibble first.
- IFG: tx_en=0 for IFG_NIBBLES cycles; frame_cnt++ on entry (not counted for underrun frames), then → IDLE.
- busy: drops in IDLE; back-to-back frames therefore start no earlier than IFG_NIBBLES+1 cycles after the last nibble.
- Output latency:
  - mii_tx_en/mii_tx_dat are registered: the value decided in a state appears on the pins next cycle.
  - Data nibble accepted at cycle t appears at t+1.
- tx_eof with tx_vld=0 is ignored.
- A 1-nibble frame gets pad + alignment.

Test Plan:
- Preamble/SFD timing, APPEND_FCS=1, padding 0:
  - Stimulus: payload "123456789" (18 nibbles 1,3,2,3,…).
  - Required: 15×0x5, 0xD, the 18 data nibbles, FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926).
  - Required: tx_en high for 42 cycles; frame_cnt=1.
- Padding, defaults:
  - Stimulus: 2-nibble payload.
  - Required: 16 preamble/SFD, 2 data, 118 zero nibbles, 8 FCS; tx_en high for exactly 144 cycles.
- Odd-length frame, MIN_DATA_NIBBLES=0: 3 nibbles → one 0x0 pad nibble precedes the FCS; 4 payload nibbles enter the CRC.
- Back-to-back: two frames with tx_vld held high → exactly 24 cycles of tx_en=0 between the last FCS nibble and the next preamble.
- Underrun:
  - Stimulus: tx_vld dropped for 1 cycle after 10 nibbles.
  - Required: one underrun pulse, FCS equals the inverse of the correct FCS, underrun_cnt=1, frame_cnt=0.
  - Required: the rest of the upstream frame is flushed through tx_ack and not transmitted.
- Async reset:
  - Stimulus: rstn low in the middle of the FCS state.
  - Required: tx_en=0 immediately, all counters 0; after release, a new frame begins with a full preamble.
